// File: rtl/adc_reg_config_pkg.sv
// Shared types and constants for the ADC register configuration sequencer.
// Enabling ADC_CFG_VERIFY_EN adds the readback states S_READ and S_CHECK.
package adc_reg_config_pkg;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned CNT_W   = 20;

  localparam logic [ADDR_W-1:0] DELAY_ENTRY_ADDR = 13'h1FFF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_PAUSE,
    S_NEXT,
    S_DONE,
    S_ERR
`ifdef ADC_CFG_VERIFY_EN
    , S_READ,
    S_CHECK
`endif
  } state_t;

endpackage

// File: rtl/adc_reg_config_table.sv
// Combinational ROM of {addr, data} configuration entries.
// TABLE_SEL 0 is the project table; TABLE_SEL 1 is a short table for simulation.
module adc_reg_table
  import adc_reg_config_pkg::*;
#(
  parameter int unsigned TABLE_SEL = 0
) (
  input  logic [IDX_W-1:0]   i_index,
  output logic [ENTRY_W-1:0] o_entry_c
);

  always_comb begin
    o_entry_c = '0;
    if (TABLE_SEL == 0) begin
      case (i_index)
        8'd0:    o_entry_c = {13'h0000, 8'h81};
        8'd1:    o_entry_c = {DELAY_ENTRY_ADDR, 8'h00};
        8'd2:    o_entry_c = {13'h0002, 8'h00};
        8'd3:    o_entry_c = {13'h0008, 8'h03};
        8'd4:    o_entry_c = {13'h0014, 8'h01};
        8'd5:    o_entry_c = {13'h0015, 8'h00};
        8'd6:    o_entry_c = {13'h0016, 8'h0C};
        8'd7:    o_entry_c = {13'h0018, 8'h40};
        8'd8:    o_entry_c = {13'h0020, 8'h00};
        8'd9:    o_entry_c = {13'h0030, 8'h18};
        8'd10:   o_entry_c = {13'h0056, 8'h00};
        8'd11:   o_entry_c = {13'h0057, 8'h00};
        8'd12:   o_entry_c = {13'h0058, 8'h00};
        8'd13:   o_entry_c = {13'h0120, 8'h02};
        8'd14:   o_entry_c = {13'h0121, 8'h01};
        8'd15:   o_entry_c = {13'h00FF, 8'h01};
        default: o_entry_c = '0;
      endcase
    end else begin
      case (i_index)
        8'd0:    o_entry_c = {13'h0000, 8'h3C};
        8'd1:    o_entry_c = {DELAY_ENTRY_ADDR, 8'h00};
        8'd2:    o_entry_c = {13'h00FF, 8'h01};
        8'd3:    o_entry_c = {13'h0008, 8'h55};
        default: o_entry_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/adc_reg_config.sv
// Walks the register table and issues one write per entry to the ADC SPI controller.
// ADC_CFG_VERIFY_EN adds a readback-and-compare step after every write.
module adc_reg_config
  import adc_reg_config_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned DELAY_CYCLES   = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic        ADDR_2BYTE     = 1'b1,
  parameter int unsigned TABLE_SEL      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index,
  output logic        spi_addr_2byte,
  output logic        cmd_write,
  input  logic        cmd_write_ack,
  output logic        cmd_read,
  input  logic        cmd_read_ack,
  output logic [12:0] write_addr,
  output logic [7:0]  write_data,
  output logic [12:0] read_addr,
  input  logic [7:0]  read_data
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_END  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;
  logic [IDX_W-1:0]    r_err_index, w_err_index_nxt;
  logic                r_cmd_write, w_cmd_write_nxt;
  logic [ADDR_W-1:0]   r_write_addr, w_write_addr_nxt;
  logic [DATA_W-1:0]   r_write_data, w_write_data_nxt;
  logic [ENTRY_W-1:0]  w_entry_raw;
  entry_t              w_entry;

  adc_reg_table #(
    .TABLE_SEL (TABLE_SEL)
  ) u_table (
    .i_index   (r_idx),
    .o_entry_c (w_entry_raw)
  );

  assign w_entry = entry_t'(w_entry_raw);

`ifdef ADC_CFG_VERIFY_EN
  logic                r_cmd_read, w_cmd_read_nxt;
  logic [ADDR_W-1:0]   r_read_addr, w_read_addr_nxt;
`endif

  // Next-state and next-output logic; every register holds unless a state changes it.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_error_nxt      = r_error;
    w_err_index_nxt  = r_err_index;
    w_cmd_write_nxt  = r_cmd_write;
    w_write_addr_nxt = r_write_addr;
    w_write_data_nxt = r_write_data;
`ifdef ADC_CFG_VERIFY_EN
    w_cmd_read_nxt   = r_cmd_read;
    w_read_addr_nxt  = r_read_addr;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_error_nxt = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cnt_nxt = '0;
        if (w_entry.addr == DELAY_ENTRY_ADDR) begin
          w_state_nxt = S_PAUSE;
        end else begin
          w_write_addr_nxt = w_entry.addr;
          w_write_data_nxt = w_entry.data;
          w_cmd_write_nxt  = 1'b1;
          w_state_nxt      = S_WRITE;
        end
      end
      // cmd_write must stay up until the ack: the controller decodes direction late.
      S_WRITE: begin
        if (cmd_write_ack) begin
          w_cmd_write_nxt = 1'b0;
          w_cnt_nxt       = '0;
`ifdef ADC_CFG_VERIFY_EN
          w_cmd_read_nxt  = 1'b1;
          w_read_addr_nxt = r_write_addr;
          w_state_nxt     = S_READ;
`else
          w_state_nxt     = S_NEXT;
`endif
        end else if (r_cnt == WDOG_END) begin
          w_cmd_write_nxt = 1'b0;
          w_error_nxt     = 1'b1;
          w_err_index_nxt = r_idx;
          w_state_nxt     = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`ifdef ADC_CFG_VERIFY_EN
      S_READ: begin
        if (cmd_read_ack) begin
          w_cmd_read_nxt = 1'b0;
          w_state_nxt    = S_CHECK;
        end else if (r_cnt == WDOG_END) begin
          w_cmd_read_nxt  = 1'b0;
          w_error_nxt     = 1'b1;
          w_err_index_nxt = r_idx;
          w_state_nxt     = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (read_data == r_write_data) begin
          w_state_nxt = S_NEXT;
        end else begin
          w_error_nxt     = 1'b1;
          w_err_index_nxt = r_idx;
          w_state_nxt     = S_ERR;
        end
      end
`endif
      S_PAUSE: begin
        if (r_cnt == DELAY_END) begin
          w_state_nxt = S_NEXT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_index  <= '0;
      r_cmd_write  <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_err_index  <= w_err_index_nxt;
      r_cmd_write  <= w_cmd_write_nxt;
      r_write_addr <= w_write_addr_nxt;
      r_write_data <= w_write_data_nxt;
    end
  end

`ifdef ADC_CFG_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_read  <= 1'b0;
      r_read_addr <= '0;
    end else begin
      r_cmd_read  <= w_cmd_read_nxt;
      r_read_addr <= w_read_addr_nxt;
    end
  end

  assign cmd_read  = r_cmd_read;
  assign read_addr = r_read_addr;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{read_data, cmd_read_ack};
  assign cmd_read    = 1'b0;
  assign read_addr   = '0;
`endif

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign err_index      = r_err_index;
  assign spi_addr_2byte = ADDR_2BYTE;
  assign cmd_write      = r_cmd_write;
  assign write_addr     = r_write_addr;
  assign write_data     = r_write_data;

endmodule

// File: tb/tb_adc_reg_config.sv
// Randomized scoreboard bench for adc_reg_config using the 4-entry test table
// {0x000:0x3C, delay, 0x0FF:0x01, 0x008:0x55}.
module tb_adc_reg_config;

  localparam int NREG = 4;
  localparam int DLY  = 100;
  localparam int TMO  = 400;
  localparam logic [12:0] DLY_ADDR = 13'h1FFF;

  typedef enum int {K_WR, K_DONE, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [12:0] addr;
    logic [7:0]  data;
    bit          after_pause;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic        clk = 1'b0;
  logic        rst, start, cmd_write_ack, cmd_read_ack;
  logic [7:0]  read_data;
  logic        busy, done, error, spi_addr_2byte, cmd_write, cmd_read;
  logic [7:0]  err_index, write_data;
  logic [12:0] write_addr, read_addr;

  logic [12:0] m_addr [NREG];
  logic [7:0]  m_data [NREG];
  int          fail_at   = -1;
  int          wr_ord    = 0;
  int          force_lat = 0;

  always #5 clk = ~clk;

  adc_reg_config #(
    .NUM_REGS       (NREG),
    .DELAY_CYCLES   (DLY),
    .TIMEOUT_CYCLES (TMO),
    .ADDR_2BYTE     (1'b1),
    .TABLE_SEL      (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_index      (err_index),
    .spi_addr_2byte (spi_addr_2byte),
    .cmd_write      (cmd_write),
    .cmd_write_ack  (cmd_write_ack),
    .cmd_read       (cmd_read),
    .cmd_read_ack   (cmd_read_ack),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .read_addr      (read_addr),
    .read_data      (read_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=event expected=none", name);
  endtask

  function automatic logic [7:0] model_data(input logic [12:0] a);
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < NREG; i++) if (m_addr[i] == a) d = m_data[i];
    return d;
  endfunction

  // Controller model: acks each write after a random latency, or never for the chosen write.
  initial begin : ctrl
    int hi;
    int lat;
    bit mute;
    hi = 0; lat = 1; mute = 1'b0;
    cmd_write_ack = 1'b0;
    forever begin
      @(negedge clk); #1;
      cmd_write_ack = 1'b0;
      if (rst || !cmd_write) begin
        hi = 0;
        if (!rst && $urandom_range(0, 15) == 0) cmd_write_ack = 1'b1;
      end else begin
        if (hi == 0) begin
          mute = (wr_ord == fail_at);
          wr_ord++;
          if (force_lat != 0) lat = force_lat;
          else lat = ($urandom_range(0, 3) == 0) ? 300 : int'($urandom_range(1, 30));
        end
        hi++;
        if (!mute && hi == lat) cmd_write_ack = 1'b1;
      end
    end
  end

  // Readback responder: returns the table value two cycles into each read.
  initial begin : rd_resp
    int rhi;
    rhi = 0;
    cmd_read_ack = 1'b0;
    read_data = 8'h00;
    forever begin
      @(negedge clk); #1;
      cmd_read_ack = 1'b0;
      if (rst || !cmd_read) rhi = 0;
      else begin
        rhi++;
        if (rhi == 2) begin
          cmd_read_ack = 1'b1;
          read_data = model_data(read_addr);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each write request, done pulse and error rise.
  initial begin : mon
    exp_t        e;
    logic        prev_cw, prev_err;
    logic [12:0] h_addr;
    logic [7:0]  h_data;
    bit          stable, busy_chk;
    int          low_cnt, hi_cnt, last_hi;
    prev_cw = 1'b0; prev_err = 1'b0; stable = 1'b1; busy_chk = 1'b0;
    low_cnt = 0; hi_cnt = 0; last_hi = 0; h_addr = '0; h_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cw = 1'b0; prev_err = 1'b0; busy_chk = 1'b0;
        low_cnt = 0; hi_cnt = 0;
        continue;
      end
      if (busy_chk) begin
        chk("busy_fall", 32'(busy), 32'd0);
        busy_chk = 1'b0;
      end
      if (cmd_write_ack && prev_cw) chk("cw_low_after_ack", 32'(cmd_write), 32'd0);
      if (cmd_write && !prev_cw) begin
        chk("rd_wr_excl", 32'(cmd_read), 32'd0);
        if (sb.size() == 0) unexpected("write_req");
        else begin
          e = sb.pop_front();
          chk("wr_kind", 32'(e.kind), 32'(K_WR));
          chk("wr_addr", 32'(write_addr), 32'(e.addr));
          chk("wr_data", 32'(write_data), 32'(e.data));
          if (e.after_pause) begin
            chk("pause_min_gap", 32'(low_cnt >= DLY), 32'd1);
            chk("pause_max_gap", 32'(low_cnt <= DLY + 16), 32'd1);
          end
        end
        h_addr = write_addr; h_data = write_data; stable = 1'b1;
        hi_cnt = 1; low_cnt = 0;
      end else if (cmd_write) begin
        hi_cnt++;
        if (write_addr !== h_addr || write_data !== h_data) stable = 1'b0;
      end else begin
        low_cnt++;
        if (prev_cw) begin
          last_hi = hi_cnt;
          chk("wr_stable", 32'(stable), 32'd1);
        end
      end
      if (error && !prev_err) begin
        if (sb.size() == 0) unexpected("error_rise");
        else begin
          e = sb.pop_front();
          chk("err_kind", 32'(e.kind), 32'(K_ERR));
          chk("err_index", 32'(err_index), 32'(e.data));
          chk("err_cw_low", 32'(cmd_write), 32'd0);
          chk("timeout_len", 32'(last_hi), 32'(TMO));
        end
        busy_chk = 1'b1;
      end
      if (done) begin
        if (sb.size() == 0) unexpected("done_pulse");
        else begin
          e = sb.pop_front();
          chk("done_kind", 32'(e.kind), 32'(K_DONE));
        end
        busy_chk = 1'b1;
      end
      prev_cw = cmd_write;
      prev_err = error;
    end
  end

  initial begin : drv
    bit ok;
    rst = 1'b1; start = 1'b0;
    m_addr[0] = 13'h000;   m_data[0] = 8'h3C;
    m_addr[1] = DLY_ADDR;  m_data[1] = 8'h00;
    m_addr[2] = 13'h0FF;   m_data[2] = 8'h01;
    m_addr[3] = 13'h008;   m_data[3] = 8'h55;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_index", 32'(err_index), 32'd0);
    chk("rst_cmd_write", 32'(cmd_write), 32'd0);
    chk("rst_cmd_read", 32'(cmd_read), 32'd0);
    chk("rst_write_addr", 32'(write_addr), 32'd0);
    chk("rst_read_addr", 32'(read_addr), 32'd0);
    chk("rst_addr_2byte", 32'(spi_addr_2byte), 32'd1);
    #1 rst = 1'b0;

    for (int r = 0; r < 14; r++) begin
      int fa, ord, exp_idx;
      bit last_delay, failed;
      if (r == 1) fa = 0;
      else fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      ord = 0; exp_idx = 0; last_delay = 1'b0; failed = 1'b0;
      for (int i = 0; i < NREG; i++) begin
        if (m_addr[i] == DLY_ADDR) begin
          last_delay = 1'b1;
          continue;
        end
        sb.push_back('{kind: K_WR, addr: m_addr[i], data: m_data[i], after_pause: last_delay});
        last_delay = 1'b0;
        if (ord == fa) begin
          sb.push_back('{kind: K_ERR, addr: 13'h0, data: 8'(i), after_pause: 1'b0});
          exp_idx = i;
          failed = 1'b1;
          break;
        end
        ord++;
      end
      if (!failed) sb.push_back('{kind: K_DONE, addr: 13'h0, data: 8'h0, after_pause: 1'b0});

      @(negedge clk); #1;
      fail_at = fa; wr_ord = 0; start = 1'b1;
      @(negedge clk);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_clears_error", 32'(error), 32'd0);
      chk("start_cw_not_yet", 32'(cmd_write), 32'd0);
      #1 start = 1'b0;
      @(negedge clk);
      chk("start_latency", 32'(cmd_write), 32'd1);
      if (r % 2 == 0) begin
        repeat ($urandom_range(1, 150)) @(negedge clk);
        #1 start = busy;
        @(negedge clk); #1 start = 1'b0;
      end
      ok = 1'b0;
      for (int c = 0; c < 6000; c++) begin
        @(negedge clk);
        if (!busy) begin
          ok = 1'b1;
          break;
        end
      end
      chk("run_finishes", 32'(ok), 32'd1);
      @(negedge clk);
      chk("error_sticky", 32'(error), 32'(failed));
      if (failed) chk("err_index_hold", 32'(err_index), 32'(exp_idx));
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a held write request.
    @(negedge clk); #1;
    fail_at = -1; wr_ord = 0; force_lat = 300;
    sb.push_back('{kind: K_WR, addr: m_addr[0], data: m_data[0], after_pause: 1'b0});
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cmd_write) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_write_reached", 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    sb.delete();
    rst = 1'b1;
    #1;
    chk("async_rst_cmd_write", 32'(cmd_write), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_error", 32'(error), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_addr_2byte", 32'(spi_addr_2byte), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    force_lat = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : global_bound
    #5_000_000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule

// File: doc/adc_reg_config.md
Name: adc_reg_config

Overview:
Power-up/reconfiguration sequencer for the ADC register interface. On `start` it walks a fixed table of {address, data} entries and issues one register write per entry through the `cmd_write`/`cmd_write_ack` handshake of the downstream ADC SPI register controller. It sits directly upstream of that controller and drives its command, address and data inputs. It supports timed pause entries and a per-transaction ack watchdog.

Parameters:
- NUM_REGS, 16: number of table entries walked, 1..256.
- DELAY_CYCLES, 100000: length of the pause for a delay entry, in clk cycles; counter is 20 bits wide.
- TIMEOUT_CYCLES, 65535: maximum wait for an ack, in clk cycles; counter is 20 bits wide.
- ADDR_2BYTE, 1: value driven on `spi_addr_2byte`.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run the table.
- busy  out  1  high while the sequence is running.
- done  out  1  one-cycle pulse when the sequence completes without error.
- error  out  1  sticky; cleared by the next accepted `start`.
- err_index  out  8  table index that failed; valid while `error`=1.
- spi_addr_2byte  out  1  constant ADDR_2BYTE.
- cmd_write  out  1  write request to the controller.
- cmd_write_ack  in  1  one-cycle ack from the controller.
- cmd_read  out  1  read request to the controller (verify feature only).
- cmd_read_ack  in  1  one-cycle ack from the controller.
- write_addr  out  13  register address.
- write_data  out  8  register data.
- read_addr  out  13  readback address.
- read_data  in  8  readback data; valid from the cycle after `cmd_read_ack`.

Behaviour:
- Reset values: all outputs 0 except `spi_addr_2byte`=ADDR_2BYTE. State returns to S_IDLE.
- A reset mid-transaction drops `cmd_*` immediately. The controller shares `rst`.
- States: S_IDLE, S_LOAD, S_WRITE, S_PAUSE, S_NEXT, S_DONE, S_ERR; plus S_READ and S_CHECK when the verify feature is compiled in.
- S_IDLE: `start`=1 → clear `error`, idx←0, go to S_LOAD.
- S_LOAD: register the table entry for idx.
  - addr==13'h1FFF → go to S_PAUSE.
  - Otherwise drive `write_addr`/`write_data` from the entry, set `cmd_write`←1, go to S_WRITE.
- S_WRITE: hold `cmd_write`, `write_addr` and `write_data` stable until `cmd_write_ack`.
  - On the edge where ack=1: `cmd_write`←0, go to S_NEXT (or S_READ when verify is enabled).
  - The controller decodes read vs write late, so `cmd_write` must never drop before the ack.
- S_PAUSE: count to DELAY_CYCLES-1, then go to S_NEXT. No commands are issued during the pause.
- S_NEXT: if idx==NUM_REGS-1 go to S_DONE; otherwise idx←idx+1 and go to S_LOAD.
- S_DONE: `done`=1 for one cycle, then S_IDLE.
- Watchdog: counter runs in S_WRITE/S_READ and resets on entry to those states.
  - Reaching TIMEOUT_CYCLES with no ack → drop `cmd_*`, `err_index`←idx, `error`←1, go to S_ERR.
- S_ERR: one cycle, then S_IDLE; `busy`←0.
- `busy` = (state != S_IDLE).
- `start` while busy is ignored, with no queuing.
- Start latency: `start` at cycle 0 → `cmd_write` high at cycle 2.
- An ack arriving outside S_WRITE/S_READ is ignored.
- `cmd_read` and `cmd_write` are never high simultaneously.

Optional Feature:
- Macro: ADC_CFG_VERIFY_EN.
- Defined:
  - After a write ack, go to S_READ: `read_addr`←entry addr, `cmd_read`←1, held until `cmd_read_ack`.
  - Then go to S_CHECK one cycle later and compare `read_data` with the entry data.
  - Equal → S_NEXT. Mismatch → error path (`err_index`=idx, S_ERR).
  - Delay entries are not verified.
- Undefined:
  - `cmd_read`=0 and `read_addr`=0 permanently.
  - S_READ and S_CHECK do not exist; `read_data` and `cmd_read_ack` are unused.

Decomposition:
- Shared package/header holds:
  - state encodings;
  - DELAY_ENTRY_ADDR = 13'h1FFF;
  - entry width (21 bits: {addr[12:0], data[7:0]}).
- One sub-module, `adc_reg_table`: combinational case ROM, 8-bit index in, 21-bit entry out.
  - Project contents are checked in; the bench compiles a test variant.

Test Plan:
- Reset asserted mid-S_WRITE → `cmd_write`, `busy` and `error` are 0 at once; `spi_addr_2byte`=1.
- Test table {0x000:0x3C, 0x0FF:0x01, 0x008:0x55}, NUM_REGS=3, controller model acks after 300 cycles → three writes in order with stable addr/data while `cmd_write` is high, `cmd_write` low the cycle after each ack, one `done` pulse, `busy` falls.
- Entry 1 = {0x1FFF, x}, DELAY_CYCLES=100 → no `cmd_write` for 100 cycles between entry 0's ack and entry 2's request.
- Model never acks, TIMEOUT_CYCLES=50 → `cmd_write` drops and `error`=1 with `err_index`=0 after 50 cycles; no `done`; a new `start` clears `error` and begins at idx 0.
- `start` pulsed during a run → ignored, each entry is written once; `start` after `done` → full rerun.
- With ADC_CFG_VERIFY_EN, model returns 0x00 for addr 0x000 (expected 0x3C) → `cmd_read` issued with `read_addr`=0x000, then `error`=1, `err_index`=0; matching data → sequence completes with `done`.
